generate_ca_buf_param: RTL and testbench
========================================

// Module: generate_ca_buf_param
// PURPOSE
//  Parametrised signed-digit operand buffer for the online CA datapath: captures one
//  (x,y) redundant digit pair per cycle and returns NUM_BANKS digit pairs per read row.
//  An internal digit counter generates the write bank and row, so no external master
//  count is needed. Adds full/overflow detection, read-validity checking and a
//  registered read handshake.
// PARAMETERS
//  NUM_BANKS       4  digits unrolled per row; power of 2, >=2; LOG2B = clog2(NUM_BANKS)
//  RAM_ADDR_WIDTH  7  row address width; depth = 2**RAM_ADDR_WIDTH rows
//  MSB_FIRST       1  1: first digit of a row lands at output bit NUM_BANKS-1; 0: at bit 0
// PORTS
//  clk         in   1               single clock, rising edge
//  asyn_reset  in   1               reset: synchronous, active-high
//  enable_all  in   1               global enable; gates writes and reads
//  wr_enable   in   1               write the digit pair this cycle
//  wr_clear    in   1               restart the write counter; clear full and overflow
//  x_value     in   2               x digit {plus,minus}
//  y_value     in   2               y digit {plus,minus}
//  rd_req      in   1               read request
//  rd_addr     in   RAM_ADDR_WIDTH  row to read
//  rd_valid    out  1               1-cycle pulse; x/y outputs updated this cycle
//  rd_err      out  1               1-cycle pulse; read refused, outputs held
//  x_plus      out  NUM_BANKS       row x plus digits
//  x_minus     out  NUM_BANKS       row x minus digits
//  y_plus      out  NUM_BANKS       row y plus digits
//  y_minus     out  NUM_BANKS       row y minus digits
//  rows_done   out  RAM_ADDR_WIDTH  number of completed rows (write counter upper field)
//  row_done    out  1               1-cycle pulse when a row's last digit is written
//  full        out  1               every row written; further writes are dropped
//  overflow    out  1               sticky: a write was attempted while full
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - digit counter cnt = 0.
//    - All outputs 0, including full, overflow, rd_valid and rd_err.
//    - RAM contents are not cleared.
//  - cnt is RAM_ADDR_WIDTH+LOG2B bits wide.
//    - sel = cnt[LOG2B-1:0]; row = cnt[top:LOG2B]; rows_done = row.
//  - Write accept (we) = enable_all & wr_enable & ~full & ~wr_clear.
//    - The digit pair is written to bank b at address row.
//    - b = NUM_BANKS-1-sel if MSB_FIRST, else sel.
//    - Then cnt increments.
//    - row_done pulses in the cycle after an accept with sel = NUM_BANKS-1.
//  - Wrap: an accept at cnt = all-ones sets cnt = 0 and full = 1 (rows_done reads 0 while full).
//  - Write attempt (enable_all & wr_enable) while full:
//    - Dropped; overflow <= 1 (sticky).
//    - cnt and RAM are unchanged.
//  - wr_clear:
//    - Sets cnt = 0, full = 0, overflow = 0 at the next edge. RAM data is retained.
//    - A write in the same cycle is dropped and does not set overflow.
//  - Read, accepted when enable_all & rd_req:
//    - The row is valid if full = 1 or rd_addr < rows_done, evaluated on pre-edge state.
//    - Valid row: the next cycle has rd_valid = 1 and outputs = that row. Latency 1.
//    - Invalid row: the next cycle has rd_err = 1; outputs hold their previous value.
//  - Read and write in the same cycle:
//    - Always allowed.
//    - A read of the row being completed by that same write is invalid (pre-edge count), so rd_err.
//    - A read of an already-completed row returns the stored data, never the in-flight digit.
//  - Output mapping for bank b:
//    - x_plus[b] = x_value[1], x_minus[b] = x_value[0].
//    - y_plus[b] = y_value[1], y_minus[b] = y_value[0].
//  - enable_all = 0: no writes and no reads; outputs and flags hold; rd_valid and rd_err are 0.
//  - Reset mid-row: the partial row is discarded; rows_done = 0; the next write goes to bank sel 0 of row 0.
// TESTING
//  T1 reset, then 8 writes (MSB_FIRST=1, NUM_BANKS=4): x = {10,01,10,00,...}, y = 01 each
//     -> row_done pulses 2x; rows_done = 2.
//     Read row 0 -> next cycle rd_valid = 1, x_plus = 4'b1010, x_minus = 4'b0100, y_plus = 0, y_minus = 4'b1111.
//  T2 3 writes only; read row 0 -> rd_err = 1, rd_valid = 0, outputs unchanged.
//     4th write together with read row 0 -> rd_err; read row 0 next cycle -> rd_valid.
//  T3 RAM_ADDR_WIDTH=2: 16 writes -> full = 1, rows_done = 0.
//     17th write -> overflow = 1, RAM row 0 unchanged.
//     wr_clear -> full = 0, overflow = 0; row 3 still readable only after it is rewritten.
//  T4 wr_clear and wr_enable in the same cycle -> cnt = 0, no write, overflow stays 0.
//  T5 enable_all = 0 with wr_enable = 1 and rd_req = 1 for 5 cycles -> cnt, flags and outputs frozen; no pulses.
//  T6 asyn_reset asserted after 2 digits of row 1 (cnt = 6)
//     -> next cycle cnt = 0, rows_done = 0, full = 0.
//     Read row 0 -> rd_err.

Source files
------------

// File: rtl/generate_ca_buf_param.sv
// Signed-digit operand buffer for the online CA datapath: one (x,y) digit
// pair written per cycle, NUM_BANKS digit pairs returned per read row.
module generate_ca_buf_param #(
    parameter int NUM_BANKS      = 4,
    parameter int RAM_ADDR_WIDTH = 7,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                      clk,
    input  logic                      asyn_reset,
    input  logic                      enable_all,
    input  logic                      wr_enable,
    input  logic                      wr_clear,
    input  logic [1:0]                x_value,
    input  logic [1:0]                y_value,
    input  logic                      rd_req,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_valid,
    output logic                      rd_err,
    output logic [NUM_BANKS-1:0]      x_plus,
    output logic [NUM_BANKS-1:0]      x_minus,
    output logic [NUM_BANKS-1:0]      y_plus,
    output logic [NUM_BANKS-1:0]      y_minus,
    output logic [RAM_ADDR_WIDTH-1:0] rows_done,
    output logic                      row_done,
    output logic                      full,
    output logic                      overflow
);

    localparam int LOG2B = $clog2(NUM_BANKS);
    localparam int CW    = RAM_ADDR_WIDTH + LOG2B;
    localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      full_q, full_d;
    logic                      overflow_q, overflow_d;
    logic                      row_done_q, row_done_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rd_err_q, rd_err_d;
    logic [NUM_BANKS-1:0]      x_plus_q, x_plus_d;
    logic [NUM_BANKS-1:0]      x_minus_q, x_minus_d;
    logic [NUM_BANKS-1:0]      y_plus_q, y_plus_d;
    logic [NUM_BANKS-1:0]      y_minus_q, y_minus_d;

    logic [LOG2B-1:0]          sel;
    logic [LOG2B-1:0]          wr_bank;
    logic [RAM_ADDR_WIDTH-1:0] row;
    logic                      wr_try;
    logic                      we;
    logic                      rd_acc;
    logic                      rd_ok;

    // Each entry packs {x_plus, x_minus, y_plus, y_minus} for one bank.
    logic [3:0] ram [NUM_BANKS][DEPTH];

    logic [NUM_BANKS-1:0] rd_xp, rd_xm, rd_yp, rd_ym;

    assign sel     = cnt_q[LOG2B-1:0];
    assign row     = cnt_q[CW-1:LOG2B];
    // NUM_BANKS is a power of two, so NUM_BANKS-1-sel is just ~sel.
    assign wr_bank = MSB_FIRST ? ~sel : sel;
    assign wr_try  = enable_all & wr_enable;
    assign we      = wr_try & ~full_q & ~wr_clear;
    assign rd_acc  = enable_all & rd_req;
    assign rd_ok   = full_q | (rd_addr < row);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_rd
        assign rd_xp[g] = ram[g][rd_addr][3];
        assign rd_xm[g] = ram[g][rd_addr][2];
        assign rd_yp[g] = ram[g][rd_addr][1];
        assign rd_ym[g] = ram[g][rd_addr][0];
    end

    always_ff @(posedge clk) begin
        if (we && !asyn_reset) begin
            ram[wr_bank][row] <= {x_value, y_value};
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        row_done_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        x_plus_d   = x_plus_q;
        x_minus_d  = x_minus_q;
        y_plus_d   = y_plus_q;
        y_minus_d  = y_minus_q;

        if (wr_clear) begin
            cnt_d      = '0;
            full_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (we) begin
            cnt_d      = cnt_q + 1'b1;
            row_done_d = (sel == LOG2B'(NUM_BANKS - 1));
            if (cnt_q == '1) begin
                full_d = 1'b1;
            end
        end else if (wr_try) begin
            overflow_d = 1'b1;
        end

        if (rd_acc) begin
            if (rd_ok) begin
                rd_valid_d = 1'b1;
                x_plus_d   = rd_xp;
                x_minus_d  = rd_xm;
                y_plus_d   = rd_yp;
                y_minus_d  = rd_ym;
            end else begin
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            cnt_q      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            row_done_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            x_plus_q   <= '0;
            x_minus_q  <= '0;
            y_plus_q   <= '0;
            y_minus_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            row_done_q <= row_done_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            x_plus_q   <= x_plus_d;
            x_minus_q  <= x_minus_d;
            y_plus_q   <= y_plus_d;
            y_minus_q  <= y_minus_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign x_plus    = x_plus_q;
    assign x_minus   = x_minus_q;
    assign y_plus    = y_plus_q;
    assign y_minus   = y_minus_q;
    assign rows_done = row;
    assign row_done  = row_done_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_generate_ca_buf_param.sv
// Directed vector bench for generate_ca_buf_param with a 4-row, 4-bank,
// MSB-first buffer.
module tb_generate_ca_buf_param;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       enable_all;
    logic       wr_enable;
    logic       wr_clear;
    logic [1:0] x_value;
    logic [1:0] y_value;
    logic       rd_req;
    logic [1:0] rd_addr;
    logic       rd_valid;
    logic       rd_err;
    logic [3:0] x_plus;
    logic [3:0] x_minus;
    logic [3:0] y_plus;
    logic [3:0] y_minus;
    logic [1:0] rows_done;
    logic       row_done;
    logic       full;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    generate_ca_buf_param #(
        .NUM_BANKS(4),
        .RAM_ADDR_WIDTH(2),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .asyn_reset(asyn_reset),
        .enable_all(enable_all),
        .wr_enable(wr_enable),
        .wr_clear(wr_clear),
        .x_value(x_value),
        .y_value(y_value),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_err(rd_err),
        .x_plus(x_plus),
        .x_minus(x_minus),
        .y_plus(y_plus),
        .y_minus(y_minus),
        .rows_done(rows_done),
        .row_done(row_done),
        .full(full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, en, we, clr;
        logic [1:0] x, y;
        logic       rq;
        logic [1:0] ra;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic rst, input logic en, input logic we, input logic clr,
        input logic [1:0] x, input logic [1:0] y,
        input logic rq, input logic [1:0] ra,
        input logic vld, input logic err,
        input logic [3:0] xp, input logic [3:0] xm,
        input logic [3:0] yp, input logic [3:0] ym,
        input logic [1:0] rdn, input logic rdone,
        input logic fl, input logic ovf
    );
        vec_t v;
        v.rst = rst; v.en = en; v.we = we; v.clr = clr;
        v.x = x; v.y = y; v.rq = rq; v.ra = ra;
        v.exp = {vld, err, xp, xm, yp, ym, rdn, rdone, fl, ovf};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        asyn_reset = v.rst;
        enable_all = v.en;
        wr_enable  = v.we;
        wr_clear   = v.clr;
        x_value    = v.x;
        y_value    = v.y;
        rd_req     = v.rq;
        rd_addr    = v.ra;
    endtask

    task automatic check(input string name, input logic [22:0] want);
        logic [22:0] got;
        got = {rd_valid, rd_err, x_plus, x_minus, y_plus, y_minus,
               rows_done, row_done, full, overflow};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got vld/err=%b%b xp=%b xm=%b yp=%b ym=%b rdn=%0d rd=%b f=%b o=%b, want vld/err=%b%b xp=%b xm=%b yp=%b ym=%b rdn=%0d rd=%b f=%b o=%b",
                name, got[22], got[21], got[20:17], got[16:13], got[12:9],
                got[8:5], got[4:3], got[2], got[1], got[0],
                want[22], want[21], want[20:17], want[16:13], want[12:9],
                want[8:5], want[4:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.exp);
    endtask

    initial begin
        vec_t h;
        drive('0);

        // reset
        add(1,0,0,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        // T1: two rows, x = 10,01,10,00 repeated, y = 01
        add(0,1,1,0, 2'b10,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b01,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b10,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 1,1,0,0);
        add(0,1,1,0, 2'b10,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 1,0,0,0);
        add(0,1,1,0, 2'b01,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 1,0,0,0);
        add(0,1,1,0, 2'b10,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 1,0,0,0);
        add(0,1,1,0, 2'b00,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 2,1,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 1,0, 4'b1010,4'b0100,4'b0000,4'b1111, 2,0,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,1, 1,0, 4'b1010,4'b0100,4'b0000,4'b1111, 2,0,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,2, 0,1, 4'b1010,4'b0100,4'b0000,4'b1111, 2,0,0,0);
        // T2: partial row is not readable
        add(1,0,0,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b01,2'b10, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b10,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b01,2'b11, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 0,1, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b01, 1,0, 0,1, 4'h0,4'h0,4'h0,4'h0, 1,1,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 1,0, 4'b0100,4'b1010,4'b1010,4'b0011, 1,0,0,0);
        // T3: fill rows 1..3, then overflow and clear
        for (int i = 0; i < 8; i++) begin
            add(0,1,1,0, 2'b11,2'b00, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011,
                (i < 3) ? 2'd1 : (i < 7) ? 2'd2 : 2'd3, (i == 3 || i == 7), 0,0);
        end
        for (int i = 0; i < 4; i++) begin
            add(0,1,1,0, 2'b10,2'b01, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011,
                (i < 3) ? 2'd3 : 2'd0, (i == 3), (i == 3), 0);
        end
        add(0,1,0,0, 2'b00,2'b00, 1,3, 1,0, 4'b1111,4'b0000,4'b0000,4'b1111, 0,0,1,0);
        add(0,1,1,0, 2'b00,2'b00, 0,0, 0,0, 4'b1111,4'b0000,4'b0000,4'b1111, 0,0,1,1);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 1,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,1,1);
        add(0,1,0,1, 2'b00,2'b00, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,3, 0,1, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        // T4: clear wins over a same-cycle write
        add(0,1,1,1, 2'b11,2'b11, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        // T5: global enable low freezes everything
        for (int i = 0; i < 5; i++) begin
            add(0,0,1,0, 2'b11,2'b11, 1,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        end
        // T6: new row 0, two digits of row 1, then reset mid-row
        add(0,1,1,0, 2'b11,2'b10, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b00, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b01, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 0,0,0,0);
        add(0,1,1,0, 2'b01,2'b00, 0,0, 0,0, 4'b0100,4'b1010,4'b1010,4'b0011, 1,1,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 1,0, 4'b1000,4'b1001,4'b1000,4'b0010, 1,0,0,0);
        add(0,1,1,0, 2'b11,2'b11, 0,0, 0,0, 4'b1000,4'b1001,4'b1000,4'b0010, 1,0,0,0);
        add(0,1,1,0, 2'b11,2'b11, 0,0, 0,0, 4'b1000,4'b1001,4'b1000,4'b0010, 1,0,0,0);
        add(1,0,0,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 0,1, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b01,2'b01, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 0,0,0,0);
        add(0,1,1,0, 2'b00,2'b00, 0,0, 0,0, 4'h0,4'h0,4'h0,4'h0, 1,1,0,0);
        add(0,1,0,0, 2'b00,2'b00, 1,0, 1,0, 4'b0000,4'b1000,4'b0000,4'b1000, 1,0,0,0);
        // completed row read while the next row is being written
        add(0,1,1,0, 2'b11,2'b11, 1,0, 1,0, 4'b0000,4'b1000,4'b0000,4'b1000, 1,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // back-to-back reads: rd_valid stays high while rd_req is held
        h = '0;
        h.en = 1'b1;
        h.rq = 1'b1;
        h.exp = {1'b1, 1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(h, $sformatf("burst%0d", i));
        end
        h.rq = 1'b0;
        h.exp = {1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b0};
        step(h, "burst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
